serial_rx_hs: RTL and testbench

SERIAL_RX_HS -- requirements
Module: serial_rx_hs

---
 rtl/serial_rx_hs.sv | 109 ++++++++++
 tb/tb_serial_rx_hs.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_rx_hs.sv
// rtl/serial_rx_hs.sv - one-bit-per-clock serial receiver with active-low data-available handshake
module serial_rx_hs #(
    parameter int N = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         rxd,
    input  logic         rfd,
    output logic         dav_,
    output logic [N-1:0] data,
    output logic         ferr,
    output logic         ovr
);
    typedef enum logic [1:0] {R_IDLE, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [1:0] {O_EMPTY, O_FULL, O_ACK} out_state_t;

    rx_state_t  r_rx_state;
    out_state_t r_out_state;
    logic [N-1:0] r_cnt;
    logic [N-1:0] r_shift;
    logic [N-1:0] r_data;
    logic         r_dav_n;
    logic         r_ferr;
    logic         r_ovr;

    logic w_load;

    // A byte is only taken when the holding register is empty before this edge.
    assign w_load = (r_rx_state == R_STOP) && rxd && (r_out_state == O_EMPTY);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rx_state <= R_IDLE;
            r_cnt      <= '0;
            r_shift    <= '0;
            r_ferr     <= 1'b0;
            r_ovr      <= 1'b0;
        end else begin
            r_ferr <= 1'b0;
            case (r_rx_state)
                R_IDLE: begin
                    if (!rxd) begin
                        r_rx_state <= R_DATA;
                        r_cnt      <= '0;
                    end
                end
                R_DATA: begin
                    r_shift <= {rxd, r_shift[N-1:1]};
                    if (r_cnt == N'(N - 1)) begin
                        r_rx_state <= R_STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                R_STOP: begin
                    r_rx_state <= R_IDLE;
                    r_cnt      <= '0;
                    if (!rxd) begin
                        r_ferr <= 1'b1;
                    end else if (r_out_state != O_EMPTY) begin
                        r_ovr <= 1'b1;
                    end
                end
                default: begin
                    r_rx_state <= R_IDLE;
                    r_cnt      <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_out_state <= O_EMPTY;
            r_dav_n     <= 1'b1;
            r_data      <= '0;
        end else begin
            case (r_out_state)
                O_EMPTY: begin
                    if (w_load) begin
                        r_out_state <= O_FULL;
                        r_dav_n     <= 1'b0;
                        r_data      <= r_shift;
                    end
                end
                O_FULL: begin
                    if (!rfd) begin
                        r_out_state <= O_ACK;
                        r_dav_n     <= 1'b1;
                    end
                end
                O_ACK: begin
                    if (rfd) begin
                        r_out_state <= O_EMPTY;
                    end
                end
                default: begin
                    r_out_state <= O_EMPTY;
                    r_dav_n     <= 1'b1;
                end
            endcase
        end
    end

    assign dav_ = r_dav_n;
    assign data = r_data;
    assign ferr = r_ferr;
    assign ovr  = r_ovr;
endmodule

// File: tb/tb_serial_rx_hs.sv
// tb/tb_serial_rx_hs.sv - scoreboard bench for serial_rx_hs
module tb_serial_rx_hs;
    localparam int N = 8;
    localparam int K_DATA = 0;
    localparam int K_FERR = 1;
    localparam int K_OVR  = 2;

    logic         clock = 1'b0;
    logic         reset;
    logic         rxd;
    logic         rfd;
    logic         dav_;
    logic [N-1:0] data;
    logic         ferr;
    logic         ovr;

    serial_rx_hs #(.N(N)) dut (
        .clock (clock),
        .reset (reset),
        .rxd   (rxd),
        .rfd   (rfd),
        .dav_  (dav_),
        .data  (data),
        .ferr  (ferr),
        .ovr   (ovr)
    );

    always #5 clock = ~clock;

    typedef struct {
        int           kind;
        logic [N-1:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Frame-level model of the consumer side: is a byte held, has it been acknowledged.
    bit   m_held, m_acked, m_ovr;
    bit   rand_rfd = 1'b0;
    logic fixed_rfd = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_held  = 1'b0;
        m_acked = 1'b0;
        m_ovr   = 1'b0;
    endtask

    function automatic logic pick_rfd();
        if (rand_rfd) return logic'($urandom_range(0, 3) != 0);
        return fixed_rfd;
    endfunction

    task automatic cycle(input logic rx, input logic rf, input bit is_stop, input logic [N-1:0] val);
        bit   load;
        exp_t e;
        load = 1'b0;
        rxd  = rx;
        rfd  = rf;
        if (is_stop) begin
            if (!rx) begin
                e.kind = K_FERR; e.val = '0; exp_q.push_back(e);
            end else if (!m_held) begin
                e.kind = K_DATA; e.val = val; exp_q.push_back(e); load = 1'b1;
            end else if (!m_ovr) begin
                m_ovr = 1'b1;
                e.kind = K_OVR; e.val = '0; exp_q.push_back(e);
            end
        end
        if (m_held && !m_acked && !rf) m_acked = 1'b1;
        else if (m_held && m_acked && rf) begin
            m_held  = 1'b0;
            m_acked = 1'b0;
        end
        if (load) m_held = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic send_frame(input logic [N-1:0] v, input logic stop);
        cycle(1'b0, pick_rfd(), 1'b0, v);
        for (int i = 0; i < N; i++) cycle(v[i], pick_rfd(), 1'b0, v);
        cycle(stop, pick_rfd(), 1'b1, v);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, pick_rfd(), 1'b0, '0);
    endtask

    task automatic ack();
        cycle(1'b1, 1'b0, 1'b0, '0);
        cycle(1'b1, 1'b1, 1'b0, '0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: turns DUT output activity into events and matches them against the queue.
    logic         prev_dav = 1'b1;
    logic         prev_ovr = 1'b0;
    logic [N-1:0] mon_data = '0;

    task automatic expect_event(input int kind, input string name, input logic [N-1:0] act);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: got unexpected event value %0h, expected no event", name, act);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || (kind == K_DATA && act !== e.val)) begin
                errors++;
                $display("FAIL %s: got kind %0d value %0h expected kind %0d value %0h",
                         name, kind, act, e.kind, e.val);
            end
            if (e.kind == K_DATA) mon_data = e.val;
        end
    endtask

    always @(negedge clock) begin
        if (reset !== 1'b0) begin
            prev_dav = 1'b1;
            prev_ovr = 1'b0;
            mon_data = '0;
        end else begin
            if (prev_dav && !dav_) expect_event(K_DATA, "data_event", data);
            else chk("data_stable", data, mon_data);
            if (ferr) expect_event(K_FERR, "ferr_event", data);
            if (ovr && !prev_ovr) expect_event(K_OVR, "ovr_event", data);
            if (!ovr && prev_ovr) chk("ovr_sticky", ovr, 1'b1);
            prev_dav = dav_;
            prev_ovr = ovr;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] v;
        logic         stop;
        rxd   = 1'b1;
        rfd   = 1'b1;
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        chk("reset_dav", dav_, 1'b1);
        chk("reset_data", data, '0);
        chk("reset_ferr", ferr, 1'b0);
        chk("reset_ovr", ovr, 1'b0);
        reset = 1'b0;
        idle(2);

        send_frame(8'h9A, 1'b1);
        chk("f9a_dav", dav_, 1'b0);
        chk("f9a_data", data, 8'h9A);
        chk("f9a_ferr", ferr, 1'b0);
        chk("f9a_ovr", ovr, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, '0);
        chk("ack_dav", dav_, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, '0);
        chk("empty_dav", dav_, 1'b1);
        chk("empty_data", data, 8'h9A);
        send_frame(8'hA5, 1'b1);
        chk("reload_data", data, 8'hA5);
        ack();

        send_frame(8'h3C, 1'b0);
        chk("ferr_pulse", ferr, 1'b1);
        chk("ferr_dav", dav_, 1'b1);
        chk("ferr_data", data, 8'hA5);
        idle(1);
        chk("ferr_clear", ferr, 1'b0);

        idle(50);
        chk("idle_dav", dav_, 1'b1);
        chk("idle_ferr", ferr, 1'b0);

        cycle(1'b0, 1'b1, 1'b0, '0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, '0);
        reset = 1'b1;
        #1;
        model_reset();
        chk("midreset_dav", dav_, 1'b1);
        chk("midreset_data", data, '0);
        chk("midreset_ferr", ferr, 1'b0);
        chk("midreset_ovr", ovr, 1'b0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        idle(3);
        send_frame(8'h55, 1'b1);
        chk("post_reset_data", data, 8'h55);
        chk("post_reset_dav", dav_, 1'b0);
        ack();

        send_frame(8'h11, 1'b1);
        idle(1);
        send_frame(8'h22, 1'b1);
        chk("ovr_flag", ovr, 1'b1);
        chk("ovr_data", data, 8'h11);
        chk("ovr_dav", dav_, 1'b0);
        ack();

        do_reset();
        rand_rfd = 1'b1;
        for (int f = 0; f < 60; f++) begin
            v    = N'($urandom);
            stop = logic'($urandom_range(0, 6) != 0);
            send_frame(v, stop);
            idle($urandom_range(0, 3));
            if (f == 30) do_reset();
        end
        rand_rfd = 1'b0;
        idle(N + 4);
        chk("queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
